// File: rtl/fog_loop_pkg.sv
// Shared types and constants for the FOG closed-loop sequencer.
package fog_loop_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_UPDATE = 2'd3
  } fog_state_e;

  localparam int unsigned MIN_HALF_PERIOD = 2;
  localparam int unsigned ACC_BIT_DEF     = 32;
  localparam int unsigned STEP_W          = 32;

endpackage

// File: rtl/fog_demod_acc.sv
// Synchronous demodulator: adds samples in half 0, subtracts them in half 1.
// o_acc is the running sum including this cycle's sample (the value acc takes unless cleared).
module fog_demod_acc
  import fog_loop_pkg::*;
#(
  parameter int unsigned ADC_BIT = 14,
  parameter int unsigned ACC_BIT = ACC_BIT_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic signed [ADC_BIT-1:0] i_sample,
  input  logic                      i_half,
  input  logic                      i_acc_en,
  input  logic                      i_clear,
  output logic signed [ACC_BIT-1:0] o_acc
);

  logic signed [ACC_BIT-1:0] acc_q;
  logic signed [ACC_BIT-1:0] ext_c;

  always_comb begin
    ext_c = ACC_BIT'(i_sample);
    o_acc = acc_q;
    if (i_acc_en) begin
      o_acc = i_half ? (acc_q - ext_c) : (acc_q + ext_c);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      acc_q <= '0;
    end else begin
      acc_q <= o_acc;
    end
  end

endmodule

// File: rtl/fog_loop_sequencer.sv
// FOG loop sequencer: modulation/trigger generation, demodulation and step integration.
// Define FOG_STEP_SAT_EN to clamp o_step to [-STEP_LIMIT, +STEP_LIMIT]; otherwise it wraps.
module fog_loop_sequencer
  import fog_loop_pkg::*;
#(
  parameter int unsigned              ADC_BIT    = 14,
  parameter int unsigned              OUTPUT_BIT = 16,
  parameter int unsigned              ACC_BIT    = ACC_BIT_DEF,
  parameter logic signed [STEP_W-1:0] STEP_LIMIT = 32'sd1000000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic [31:0]                  i_half_period,
  input  logic [31:0]                  i_wait_cnt,
  input  logic signed [OUTPUT_BIT-1:0] i_mod_amp,
  input  logic signed [ADC_BIT-1:0]    i_adc,
  input  logic [4:0]                   i_gain_shift,
  input  logic                         i_polarity,
  output logic                         o_trig,
  output logic signed [OUTPUT_BIT-1:0] o_mod,
  output logic signed [STEP_W-1:0]     o_step,
  output logic                         o_fb_on,
  output logic signed [ACC_BIT-1:0]    o_err,
  output logic                         o_err_valid
);

  localparam int unsigned SUM_W = STEP_W + 1;

`ifdef FOG_STEP_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  fog_state_e                  state_q;
  logic [31:0]                 cnt_q;
  logic                        half_q;
  logic [31:0]                 hp_q;
  logic [31:0]                 wait_q;
  logic                        trig_q;
  logic signed [OUTPUT_BIT-1:0] mod_q;
  logic signed [STEP_W-1:0]    step_q;
  logic                        fb_on_q;
  logic signed [ACC_BIT-1:0]   err_q;
  logic                        err_valid_q;

  logic [31:0]                 hp_cfg_c;
  logic                        last_c;
  logic                        end_c;
  logic                        acc_en_c;
  logic                        acc_clr_c;
  logic signed [ACC_BIT-1:0]   acc_sum_c;
  logic signed [OUTPUT_BIT-1:0] neg_amp_c;
  logic signed [ACC_BIT-1:0]   err_pol_c;
  logic signed [ACC_BIT-1:0]   err_sh_c;
  logic signed [SUM_W-1:0]     sum_c;
  logic signed [SUM_W-1:0]     lim_c;
  logic signed [STEP_W-1:0]    step_d;

  // Period bookkeeping and integrator arithmetic
  always_comb begin
    hp_cfg_c  = (i_half_period < 32'(MIN_HALF_PERIOD)) ? 32'(MIN_HALF_PERIOD) : i_half_period;
    last_c    = (cnt_q == (hp_q - 32'd1));
    end_c     = (state_q == ST_RUN) && last_c && half_q;
    acc_en_c  = (state_q == ST_RUN) && (cnt_q >= wait_q);
    acc_clr_c = !i_en || (state_q != ST_RUN) || end_c;
    neg_amp_c = -i_mod_amp;
    err_pol_c = i_polarity ? -err_q : err_q;
    err_sh_c  = err_pol_c >>> i_gain_shift;
    sum_c     = SUM_W'(step_q) + SUM_W'(err_sh_c);
    lim_c     = SUM_W'(STEP_LIMIT);
    step_d    = sum_c[STEP_W-1:0];
    if (SAT_EN) begin
      if (sum_c > lim_c) begin
        step_d = STEP_LIMIT;
      end else if (sum_c < -lim_c) begin
        step_d = -STEP_LIMIT;
      end
    end
  end

  fog_demod_acc #(
    .ADC_BIT (ADC_BIT),
    .ACC_BIT (ACC_BIT)
  ) u_demod (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_sample (i_adc),
    .i_half   (half_q),
    .i_acc_en (acc_en_c),
    .i_clear  (acc_clr_c),
    .o_acc    (acc_sum_c)
  );

  // Sequencer FSM with registered outputs; disable behaves like reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || !i_en) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      half_q      <= 1'b0;
      hp_q        <= 32'(MIN_HALF_PERIOD);
      wait_q      <= '0;
      trig_q      <= 1'b0;
      mod_q       <= '0;
      step_q      <= '0;
      fb_on_q     <= 1'b0;
      err_q       <= '0;
      err_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_START;
        end
        ST_START: begin
          hp_q    <= hp_cfg_c;
          wait_q  <= i_wait_cnt;
          cnt_q   <= '0;
          half_q  <= 1'b0;
          fb_on_q <= 1'b1;
          mod_q   <= i_mod_amp;
          trig_q  <= 1'b0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          trig_q      <= last_c;
          err_valid_q <= 1'b0;
          if (last_c) begin
            cnt_q <= '0;
            if (half_q) begin
              half_q      <= 1'b0;
              mod_q       <= i_mod_amp;
              err_q       <= acc_sum_c;
              err_valid_q <= 1'b1;
              state_q     <= ST_UPDATE;
            end else begin
              half_q <= 1'b1;
              mod_q  <= neg_amp_c;
            end
          end else begin
            cnt_q <= cnt_q + 32'd1;
            mod_q <= half_q ? neg_amp_c : i_mod_amp;
          end
        end
        ST_UPDATE: begin
          step_q      <= step_d;
          hp_q        <= hp_cfg_c;
          wait_q      <= i_wait_cnt;
          cnt_q       <= '0;
          half_q      <= 1'b0;
          mod_q       <= i_mod_amp;
          trig_q      <= 1'b0;
          err_valid_q <= 1'b0;
          state_q     <= ST_RUN;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_trig      = trig_q;
  assign o_mod       = mod_q;
  assign o_step      = step_q;
  assign o_fb_on     = fb_on_q;
  assign o_err       = err_q;
  assign o_err_valid = err_valid_q;

endmodule
